// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: bus widths, SPI command byte
// layout, command decoder state encoding and the register map.
package pwm_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // Command byte layout: [7] 1=write/0=read, [6] reserved (must be 0), [5:0] address
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_RSVD_BIT = 6;

    // Decoder states; plain 2-bit constants so legacy code can compare raw values
    typedef logic [1:0] dec_state_t;
    localparam dec_state_t ST_IDLE    = 2'd0;
    localparam dec_state_t ST_WR_DATA = 2'd1;
    localparam dec_state_t ST_RD_DATA = 2'd2;
    localparam dec_state_t ST_DISCARD = 2'd3;

    // Register map shared with the register file
    localparam logic [ADDR_W-1:0] REG_CTRL    = 6'h00;
    localparam logic [ADDR_W-1:0] REG_PERIOD  = 6'h01;
    localparam logic [ADDR_W-1:0] REG_DUTY0   = 6'h02;
    localparam logic [ADDR_W-1:0] REG_DUTY1   = 6'h03;
    localparam logic [ADDR_W-1:0] REG_STATUS  = 6'h0A;

endpackage

// File: rtl/instr_decoder.sv
// Byte-level command decoder between the SPI bridge and the PWM register
// file. Parses a command byte followed by a data (write) or dummy (read)
// byte and issues single-cycle read/write strobes.
// Optional feature macro: DECODER_BURST_EN -- keeps issuing accesses to
// consecutive addresses for every further byte until the frame ends.
module instr_decoder #(
    parameter int ADDR_W = pwm_pkg::ADDR_W,
    parameter int DATA_W = pwm_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_active,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
);
    import pwm_pkg::*;

    dec_state_t        state_q, state_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dw_q, dw_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    // Next-state and output decode; outputs are all registered from *_d
    always_comb begin
        state_d = state_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        addr_d  = addr_q;
        dw_d    = dw_q;
        dout_d  = dout_q;

        // Register file answers combinationally while read is high
        if (read_q)
            dout_d = data_read;

`ifdef DECODER_BURST_EN
        // Advance to the next register once the write pulse has gone out
        if (write_q)
            addr_d = addr_q + ADDR_W'(1);
`endif

        if (!frame_active) begin
            // Chip-select gone: abandon the command, drop any byte this cycle.
            // A write pulse already registered still completes on its own.
            state_d = ST_IDLE;
        end else if (byte_sync) begin
            case (state_q)
                ST_IDLE: begin
                    addr_d = data_in[ADDR_W-1:0];
                    if (data_in[CMD_RSVD_BIT]) begin
                        state_d = ST_DISCARD;
                    end else if (data_in[CMD_RW_BIT]) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_DATA;
                        read_d  = 1'b1;
                    end
                end
                ST_WR_DATA: begin
                    write_d = 1'b1;
                    dw_d    = data_in;
`ifdef DECODER_BURST_EN
                    state_d = ST_WR_DATA;
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_RD_DATA: begin
                    // The byte itself is the dummy that shifted data_out out
`ifdef DECODER_BURST_EN
                    addr_d  = addr_q + ADDR_W'(1);
                    read_d  = 1'b1;
                    state_d = ST_RD_DATA;
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_DISCARD: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            dw_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            dw_q    <= dw_d;
            dout_q  <= dout_d;
        end
    end

    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = dw_q;
    assign data_out   = dout_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed bench for instr_decoder (default build, burst feature off).
// Each table row is one clock cycle: inputs are applied just after the
// rising edge and the registered outputs are checked on the falling edge.
module tb_instr_decoder;

    logic       clk;
    logic       rst_n;
    logic       frame_active;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_write;
    logic [7:0] data_read;

    int n_vec = 0;
    int n_err = 0;

    instr_decoder dut (
        .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
        .byte_sync(byte_sync), .data_in(data_in), .data_out(data_out),
        .read(read), .write(write), .addr(addr), .data_write(data_write),
        .data_read(data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: 0xA5 at 0x0A, otherwise 0x40 | addr
    assign data_read = (addr == 6'h0A) ? 8'hA5 : {2'b01, addr};

    typedef struct {
        logic       fa;
        logic       bs;
        logic [7:0] din;
        logic       rd;
        logic       wr;
        logic [5:0] ad;
        logic [7:0] dw;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fa, input logic bs, input logic [7:0] din,
                       input logic rd, input logic wr, input logic [5:0] ad,
                       input logic [7:0] dw, input logic [7:0] dout);
        vec_t v;
        v.fa = fa; v.bs = bs; v.din = din;
        v.rd = rd; v.wr = wr; v.ad = ad; v.dw = dw; v.dout = dout;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_active = 1'b0; byte_sync = 1'b0; data_in = 8'h00;
        #3;
        chk("reset_outputs", {read, write, addr, data_write, data_out}, 32'h0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        //   fa bs din      rd wr addr   dw     dout
        // single write: 0x80, 0x34
        add(0, 0, 8'h00,  0, 0, 6'h00, 8'h00, 8'h00);
        add(1, 0, 8'h00,  0, 0, 6'h00, 8'h00, 8'h00);
        add(1, 1, 8'h80,  0, 0, 6'h00, 8'h00, 8'h00);
        add(1, 0, 8'h00,  0, 0, 6'h00, 8'h00, 8'h00);
        add(1, 1, 8'h34,  0, 0, 6'h00, 8'h00, 8'h00);
        add(1, 0, 8'h00,  0, 1, 6'h00, 8'h34, 8'h00);
        add(0, 0, 8'h00,  0, 0, 6'h00, 8'h34, 8'h00);
        // read of 0x0A, then dummy byte
        add(1, 0, 8'h00,  0, 0, 6'h00, 8'h34, 8'h00);
        add(1, 1, 8'h0A,  0, 0, 6'h00, 8'h34, 8'h00);
        add(1, 0, 8'h00,  1, 0, 6'h0A, 8'h34, 8'h00);
        add(1, 0, 8'h00,  0, 0, 6'h0A, 8'h34, 8'hA5);
        add(1, 1, 8'h00,  0, 0, 6'h0A, 8'h34, 8'hA5);
        add(1, 0, 8'h00,  0, 0, 6'h0A, 8'h34, 8'hA5);
        add(0, 0, 8'h00,  0, 0, 6'h0A, 8'h34, 8'hA5);
        // reserved bit: 0xC3, 0x55 discarded; then write 0x11 to 0x03
        add(1, 1, 8'hC3,  0, 0, 6'h0A, 8'h34, 8'hA5);
        add(1, 0, 8'h00,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(1, 1, 8'h55,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(1, 0, 8'h00,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(0, 0, 8'h00,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(1, 1, 8'h83,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(1, 0, 8'h00,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(1, 1, 8'h11,  0, 0, 6'h03, 8'h34, 8'hA5);
        add(1, 0, 8'h00,  0, 1, 6'h03, 8'h11, 8'hA5);
        add(0, 0, 8'h00,  0, 0, 6'h03, 8'h11, 8'hA5);
        // abort after 0x85; next frame 0x05 is a read command
        add(1, 1, 8'h85,  0, 0, 6'h03, 8'h11, 8'hA5);
        add(1, 0, 8'h00,  0, 0, 6'h05, 8'h11, 8'hA5);
        add(0, 0, 8'h00,  0, 0, 6'h05, 8'h11, 8'hA5);
        add(1, 1, 8'h05,  0, 0, 6'h05, 8'h11, 8'hA5);
        add(1, 0, 8'h00,  1, 0, 6'h05, 8'h11, 8'hA5);
        add(1, 0, 8'h00,  0, 0, 6'h05, 8'h11, 8'h45);
        add(1, 1, 8'h00,  0, 0, 6'h05, 8'h11, 8'h45);
        add(0, 0, 8'h00,  0, 0, 6'h05, 8'h11, 8'h45);
        // byte_sync outside a frame is ignored
        add(0, 1, 8'h8A,  0, 0, 6'h05, 8'h11, 8'h45);
        add(0, 0, 8'h00,  0, 0, 6'h05, 8'h11, 8'h45);
        // scheduled write completes even though frame drops in the pulse cycle
        add(1, 1, 8'h81,  0, 0, 6'h05, 8'h11, 8'h45);
        add(1, 0, 8'h00,  0, 0, 6'h01, 8'h11, 8'h45);
        add(1, 1, 8'h77,  0, 0, 6'h01, 8'h11, 8'h45);
        add(0, 0, 8'h00,  0, 1, 6'h01, 8'h77, 8'h45);
        add(0, 0, 8'h00,  0, 0, 6'h01, 8'h77, 8'h45);
        // data byte coinciding with frame drop is dropped, FSM back to IDLE
        add(1, 1, 8'h82,  0, 0, 6'h01, 8'h77, 8'h45);
        add(1, 0, 8'h00,  0, 0, 6'h02, 8'h77, 8'h45);
        add(0, 1, 8'h99,  0, 0, 6'h02, 8'h77, 8'h45);
        add(1, 0, 8'h00,  0, 0, 6'h02, 8'h77, 8'h45);
        add(1, 1, 8'h07,  0, 0, 6'h02, 8'h77, 8'h45);
        add(1, 0, 8'h00,  1, 0, 6'h07, 8'h77, 8'h45);
        add(1, 0, 8'h00,  0, 0, 6'h07, 8'h77, 8'h47);
        add(0, 0, 8'h00,  0, 0, 6'h07, 8'h77, 8'h47);
        // 0xBF, 0x01, 0x02: write 0x01 to 0x3F, then 0x02 is a read of 0x02
        add(1, 1, 8'hBF,  0, 0, 6'h07, 8'h77, 8'h47);
        add(1, 0, 8'h00,  0, 0, 6'h3F, 8'h77, 8'h47);
        add(1, 1, 8'h01,  0, 0, 6'h3F, 8'h77, 8'h47);
        add(1, 0, 8'h00,  0, 1, 6'h3F, 8'h01, 8'h47);
        add(1, 1, 8'h02,  0, 0, 6'h3F, 8'h01, 8'h47);
        add(1, 0, 8'h00,  1, 0, 6'h02, 8'h01, 8'h47);
        add(1, 0, 8'h00,  0, 0, 6'h02, 8'h01, 8'h42);
        add(0, 0, 8'h00,  0, 0, 6'h02, 8'h01, 8'h42);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            frame_active = tbl[i].fa; byte_sync = tbl[i].bs; data_in = tbl[i].din;
            @(negedge clk);
            chk($sformatf("vec%0d {rd,wr,addr,dw,dout}", i),
                {read, write, addr, data_write, data_out},
                {tbl[i].rd, tbl[i].wr, tbl[i].ad, tbl[i].dw, tbl[i].dout});
            if (read && write) chk($sformatf("vec%0d rd_wr_exclusive", i), 1, 0);
        end

        // async reset while in WR_DATA
        @(posedge clk); #1 frame_active = 1'b1; byte_sync = 1'b1; data_in = 8'h84;
        @(posedge clk); #1 byte_sync = 1'b0; data_in = 8'h00;
        @(negedge clk);
        chk("wr_cmd_addr", {24'h0, 2'b00, addr}, 32'h04);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {read, write, addr, data_write, data_out}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        // first byte after release is a command (read of 0x11), never write data
        @(posedge clk); #1 byte_sync = 1'b1; data_in = 8'h11;
        @(posedge clk); #1 byte_sync = 1'b0;
        @(negedge clk);
        chk("post_reset_read", {read, write, addr}, {1'b1, 1'b0, 6'h11});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_reset_nostrobe%0d", k), {read, write}, 2'b00);
        end
        chk("post_reset_dout", {24'h0, data_out}, 32'h51);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
Byte-level command decoder between the SPI bridge and the PWM register file. It takes whole bytes from the bridge and parses a two-byte command/data protocol. It issues single-cycle read or write strobes with a 6-bit address and 8-bit write data to the register file. For reads, it captures the register file's combinational read data and hands it to the bridge for shift-out during the next byte.

Parameters:
ADDR_W, 6, register address width; must match the register file address bus.
DATA_W, 8, byte width on both the bridge side and the register side.

Ports:
clk  input  1  peripheral clock
rst_n  input  1  reset, asynchronous, active-low
frame_active  input  1  high while the SPI chip-select is asserted; already synchronous to clk
byte_sync  input  1  one-cycle pulse: data_in holds a complete received byte
data_in  input  DATA_W  byte received from the bridge
data_out  output  DATA_W  byte the bridge shifts out on the next transfer
read  output  1  one-cycle register read strobe
write  output  1  one-cycle register write strobe
addr  output  ADDR_W  register address, valid while read or write is high
data_write  output  DATA_W  register write data, valid while write is high
data_read  input  DATA_W  combinational register read data, valid in the same cycle as read

Behaviour:
- Reset values: read=0, write=0, addr=0, data_write=0, data_out=0, FSM=IDLE.
- Command byte format:
  - bit7: 1 = write, 0 = read.
  - bit6: reserved; must be 0.
  - bits5:0: address.
- All outputs are registered.
- FSM states: IDLE, WR_DATA, RD_DATA, DISCARD.
- IDLE, on byte_sync:
  - Latch addr <= data_in[5:0].
  - bit6=1 -> DISCARD. No access is issued.
  - bit7=1 -> WR_DATA.
  - bit7=0 -> RD_DATA. In cycle N+1 (N = byte_sync cycle) read=1 with the new addr. data_read is sampled at the end of N+1, so data_out updates in cycle N+2. read is a single cycle.
- WR_DATA, on byte_sync (cycle M):
  - In cycle M+1: write=1, data_write=data_in, addr unchanged.
  - Return to IDLE.
- RD_DATA, on byte_sync: the received byte is ignored (it is the dummy byte that clocks data_out out). Return to IDLE.
- DISCARD, on byte_sync: drop the byte and return to IDLE.
- data_out holds its value until the next read capture. It is not cleared on return to IDLE.
- frame_active=0:
  - FSM forced to IDLE on the next edge from any state.
  - A byte_sync in the same cycle is dropped.
  - A write already scheduled (pulse due next cycle) still completes. No new strobe is generated.
- A byte_sync arriving while frame_active=0 is ignored.
- read and write are never high in the same cycle.
- addr changes only on acceptance of a command byte, or on auto-increment when the feature is enabled.
- Address arithmetic is modulo 2^ADDR_W: 6'h3F + 1 = 6'h00.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). No strobe is emitted after reset release until a new command byte arrives.

Optional Feature:
Macro: DECODER_BURST_EN
- With the macro defined:
  - After a write data byte the FSM stays in WR_DATA, with addr incremented by 1 in the cycle after the write pulse.
  - After the dummy byte in RD_DATA, addr is incremented and a new read is issued. The same N+1/N+2 timing applies, using the byte_sync of the dummy byte.
  - Bursts continue until frame_active=0.
- Without the macro: strictly one access per command byte; FSM returns to IDLE as described above.

Decomposition:
- Shared package pwm_pkg:
  - ADDR_W and DATA_W constants.
  - Command bit positions: CMD_RW_BIT=7, CMD_RSVD_BIT=6.
  - Decoder state typedef.
  - Register address localparams shared with the register file.
- No sub-module; single FSM plus output registers.

Test Plan:
- Write: frame with bytes 0x80, 0x34 -> one-cycle write with addr=0x00, data_write=0x34, one cycle after the second byte_sync; read stays 0 throughout.
- Read: register file returns 0xA5 at addr 0x0A; frame with byte 0x0A -> read=1, addr=0x0A in cycle N+1; data_out=0xA5 from N+2; dummy byte 0x00 causes no strobe.
- Reserved bit: bytes 0xC3, 0x55 -> no read or write; next frame 0x83, 0x11 writes 0x11 to addr 0x03.
- Abort: frame_active drops after byte 0x85 -> FSM back in IDLE; a new frame starting with 0x05 is treated as a command (read of 0x05), not as data.
- Async reset while in WR_DATA -> all outputs 0 immediately; no write pulse after release.
- DECODER_BURST_EN: bytes 0xBF, 0x01, 0x02 -> write 0x01 to addr 0x3F, then write 0x02 to addr 0x00 (wrap); without the macro, 0x02 is decoded as a read command for addr 0x02.
